// File: rtl/bp_update_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_update_sched: in-order queue that schedules branch-predictor updates
// into a single-write-port BTB/counter table.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bp_update_sched #(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 2,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_valid,
  input  logic [31:0]                upd_pc,
  input  logic [31:0]                upd_target,
  input  logic                       upd_taken,
  input  logic                       upd_mispredict,
  input  logic [CNT_W-1:0]           upd_counter,
  input  logic                       flush,
  input  logic                       tbl_ready,
  output logic                       tbl_wr_en,
  output logic [31:0]                tbl_wr_pc,
  output logic [31:0]                tbl_wr_target,
  output logic [CNT_W-1:0]           tbl_wr_counter,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QC_W  = PTR_W + 1;
  localparam logic [QC_W-1:0] FULL_CNT = QC_W'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
  state_t state;

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [QC_W-1:0]  count;

  logic [CNT_W-1:0] new_cnt;
  logic [31:0]      pc_aligned;
  logic             enq, full, pop, push, ovr, drop, fwd;
  logic [PTR_W-1:0] last_ptr, next_rd, mem_idx;

  assign pc_aligned = {upd_pc[31:2], 2'b00};
  assign new_cnt    = upd_taken ? ((&upd_counter) ? upd_counter : upd_counter + CNT_W'(1))
                                : ((upd_counter == '0) ? upd_counter : upd_counter - CNT_W'(1));

  assign full     = (count == FULL_CNT);
  assign pop      = (state == WRITE) && tbl_ready;
  assign enq      = upd_valid && !flush;
  assign push     = enq && !full;
  assign last_ptr = wr_ptr - PTR_W'(1);
  assign next_rd  = rd_ptr + PTR_W'(1);
  assign ovr      = enq && full && upd_mispredict && !((state == WRITE) && (last_ptr == rd_ptr));
  assign drop     = enq && full && !ovr;
  assign mem_idx  = push ? wr_ptr : last_ptr;
  // An overwrite that lands on the entry about to be presented must be seen by the table.
  assign fwd      = ovr && (last_ptr == next_rd);

  assign q_count = count;

  always_ff @(posedge clk) begin
    if (push || ovr) begin
      pc_mem[mem_idx]  <= pc_aligned;
      tgt_mem[mem_idx] <= upd_target;
      cnt_mem[mem_idx] <= new_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      q_full         <= 1'b0;
      drop_cnt       <= '0;
      tbl_wr_en      <= 1'b0;
      tbl_wr_pc      <= '0;
      tbl_wr_target  <= '0;
      tbl_wr_counter <= '0;
    end else begin
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + DROP_W'(1);

      if (flush) begin
        state     <= IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        q_full    <= 1'b0;
        tbl_wr_en <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        count  <= count + QC_W'(push) - QC_W'(pop);
        q_full <= ((count + QC_W'(push) - QC_W'(pop)) == FULL_CNT);

        case (state)
          IDLE: begin
            if (count != '0) begin
              tbl_wr_pc      <= pc_mem[rd_ptr];
              tbl_wr_target  <= tgt_mem[rd_ptr];
              tbl_wr_counter <= cnt_mem[rd_ptr];
              tbl_wr_en      <= 1'b1;
              state          <= WRITE;
            end
          end
          WRITE: begin
            if (tbl_ready) begin
              rd_ptr <= next_rd;
              if (count > QC_W'(1)) begin
                tbl_wr_pc      <= fwd ? pc_aligned : pc_mem[next_rd];
                tbl_wr_target  <= fwd ? upd_target : tgt_mem[next_rd];
                tbl_wr_counter <= fwd ? new_cnt    : cnt_mem[next_rd];
              end else begin
                tbl_wr_en <= 1'b0;
                state     <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Schedules branch-predictor update packets from the branch verify stage into the single-write-port predictor tables (BTB target and 2-bit counter arrays).
- Buffers updates in a small in-order queue and holds each write until the table accepts it.
- Computes the new saturating counter and drops updates under overflow or flush.
- Sits between the branch verify unit and the fetch-stage predictor; fetch lookups take precedence, signalled by tbl_ready low.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- CNT_W, 2, width of the predictor saturating counter.
- DROP_W, 16, width of the dropped-update statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- upd_valid  in  1  update packet present this cycle
- upd_pc  in  32  branch PC; bits [1:0] are ignored and forced to zero in the queue
- upd_target  in  32  resolved target
- upd_taken  in  1  resolved direction
- upd_mispredict  in  1  packet is a misprediction
- upd_counter  in  CNT_W  counter value read at prediction time
- flush  in  1  discard all queued, not-yet-accepted updates
- tbl_ready  in  1  table write port free this cycle
- tbl_wr_en  out  1  write request
- tbl_wr_pc  out  32  write index PC
- tbl_wr_target  out  32  target to write
- tbl_wr_counter  out  CNT_W  new counter value
- q_count  out  $clog2(DEPTH)+1  occupancy
- q_full  out  1  q_count == DEPTH
- drop_cnt  out  DROP_W  updates dropped since reset

Behaviour:
- Reset (synchronous):
  - Queue empties.
  - tbl_wr_en=0, tbl_wr_pc=0, tbl_wr_target=0, tbl_wr_counter=0.
  - q_count=0, q_full=0, drop_cnt=0.
  - FSM goes to IDLE.
  - A reset asserted while a write is pending abandons it; no write completes.
- Counter arithmetic, applied at enqueue:
  - If upd_taken, new = (upd_counter == all-ones) ? upd_counter : upd_counter+1.
  - Otherwise, new = (upd_counter == 0) ? 0 : upd_counter-1.
  - The queue stores the new value, not upd_counter.
- Queue: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Enqueue when upd_valid && !flush:
  - Not full: write the entry at the tail.
  - Full and upd_mispredict=0: discard the packet and increment drop_cnt.
  - Full and upd_mispredict=1: overwrite the newest (tail-1) entry, unless that entry is the head and is currently being presented (WRITE state). In that case discard the packet and increment drop_cnt.
  - Count is unchanged on overwrite.
  - drop_cnt saturates at all-ones.
- FSM states IDLE and WRITE:
  - IDLE: tbl_wr_en=0. If count != 0 at the clock edge, load the head into the tbl_wr_* registers and go to WRITE next cycle.
  - Latency: a packet enqueued into an empty queue at edge N drives tbl_wr_en=1 from edge N+1. There is no combinational bypass.
  - WRITE: tbl_wr_en=1. The tbl_wr_* outputs are held stable while tbl_ready=0.
  - When tbl_wr_en && tbl_ready, the head pops. If another entry remains (excluding one enqueued in the same cycle), load it and stay in WRITE, so writes are back-to-back. Otherwise return to IDLE.
- Simultaneous enqueue and pop in one cycle:
  - Count is unchanged.
  - The full check uses occupancy before the pop, so a packet arriving when full during a pop is handled by the overflow rules.
- Flush:
  - Next cycle: count=0, pointers equal, FSM in IDLE, tbl_wr_en=0.
  - A write accepted in the flush cycle (tbl_wr_en && tbl_ready) still counts as completed.
  - A packet arriving with flush is discarded and does not increment drop_cnt.
- q_full and q_count are registered and reflect state after the last edge.

Test Plan:
- Single update: reset; upd_valid=1, pc=0x1000_0010, target=0x1000_0100, taken=1, counter=2'b01, tbl_ready=1 -> the next cycle shows tbl_wr_en=1, pc 0x1000_0010, target 0x1000_0100, counter 2'b10; the cycle after shows tbl_wr_en=0 and q_count=0.
- Saturation: taken=1, counter=2'b11 -> wr_counter=2'b11. Taken=0, counter=2'b00 -> wr_counter=2'b00.
- Backpressure: hold tbl_ready=0 while sending 4 packets A–D -> q_full=1; tbl_wr_* holds A with no change. Send a fifth non-mispredict packet -> drop_cnt=1. Send a sixth with mispredict=1 -> D is replaced. Raise tbl_ready -> the table writes A, B, C, then the replacement on consecutive cycles.
- Wrap-around: stream 10 packets at tbl_ready=1 -> all 10 are written in order with no drops, and q_count never exceeds 2.
- Flush: with 3 entries queued and tbl_ready=0, assert flush -> the next cycle shows tbl_wr_en=0, q_count=0, drop_cnt unchanged.
- Reset mid-write: tbl_wr_en=1 with tbl_ready=0, assert reset -> the next cycle shows all outputs at 0; a later tbl_ready=1 causes no write.
